// File: rtl/crc5_serial_unit.sv
// Serial CRC-5 generator/checker with valid/ready handshakes (LSB-first payload, complemented CRC MSB-first).
// Optional build macro CRC5_ERRCNT_EN adds a saturating check-failure counter on err_count.
module crc5_serial_unit #(
   parameter int         DATA_BITS = 11,
   parameter logic [4:0] POLY      = 5'b00101,
   parameter logic [4:0] INIT      = 5'b11111,
   parameter logic [4:0] RESIDUE   = 5'b01100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       out_valid,
   output logic       out_bit,
   input  logic       out_ready,
   output logic       busy,
   output logic       done,
   output logic       crc_ok,
   output logic [4:0] crc_val
`ifdef CRC5_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_DONE} state_t;

   localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);
   localparam logic [5:0] TAIL_LAST = 6'd4;

   state_t     state_reg, state_next;
   logic [4:0] crc_reg, crc_next;
   logic [5:0] cnt_reg, cnt_next;
   logic       mode_reg, mode_next;
   logic       crc_ok_reg, crc_ok_next;
   logic       fb;
   logic [4:0] crc_upd;

   // One feedback XOR, then one tap XOR per register bit (tap gated by POLY).
   assign fb = crc_reg[4] ^ in_bit;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_tap
         if (gi == 0) begin : g_lsb
            assign crc_upd[gi] = fb & POLY[gi];
         end else begin : g_mid
            assign crc_upd[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         crc_reg    <= INIT;
         cnt_reg    <= 6'd0;
         mode_reg   <= 1'b0;
         crc_ok_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         crc_reg    <= crc_next;
         cnt_reg    <= cnt_next;
         mode_reg   <= mode_next;
         crc_ok_reg <= crc_ok_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      crc_next    = crc_reg;
      cnt_next    = cnt_reg;
      mode_next   = mode_reg;
      crc_ok_next = crc_ok_reg;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_bit     = 1'b0;
      done        = 1'b0;
      crc_ok      = crc_ok_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next  = ST_DATA;
               crc_next    = INIT;
               cnt_next    = 6'd0;
               mode_next   = mode;
               crc_ok_next = 1'b0;
            end
         end
         ST_DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               crc_next = crc_upd;
               if (cnt_reg == DATA_LAST) begin
                  state_next = ST_TAIL;
                  cnt_next   = 6'd0;
               end else begin
                  cnt_next = cnt_reg + 6'd1;
               end
            end
         end
         ST_TAIL: begin
            if (mode_reg) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  crc_next = crc_upd;
                  if (cnt_reg == TAIL_LAST) begin
                     state_next = ST_DONE;
                     cnt_next   = 6'd0;
                  end else begin
                     cnt_next = cnt_reg + 6'd1;
                  end
               end
            end else begin
               // out_bit derives from crc_reg, which only moves on a transfer, so it holds under backpressure.
               out_valid = 1'b1;
               out_bit   = ~crc_reg[4];
               if (out_ready) begin
                  crc_next = {crc_reg[3:0], 1'b0};
                  if (cnt_reg == TAIL_LAST) begin
                     state_next = ST_DONE;
                     cnt_next   = 6'd0;
                  end else begin
                     cnt_next = cnt_reg + 6'd1;
                  end
               end
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            crc_ok      = mode_reg ? (crc_reg == RESIDUE) : 1'b1;
            crc_ok_next = crc_ok;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy    = (state_reg != ST_IDLE);
   assign crc_val = crc_reg;

`ifdef CRC5_ERRCNT_EN
   logic [7:0] err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 8'd0;
      end else if (state_reg == ST_DONE && mode_reg && crc_reg != RESIDUE && err_reg != 8'hFF) begin
         err_reg <= err_reg + 8'd1;
      end
   end

   assign err_count = err_reg;
`endif

endmodule

// File: tb/tb_crc5_serial_unit.sv
// Self-checking bench for crc5_serial_unit: count-based frame model checked every cycle plus literal pins.
module tb_crc5_serial_unit;
   localparam int         DB   = 11;
   localparam logic [4:0] POLY = 5'b00101;
   localparam logic [4:0] INIT = 5'b11111;
   localparam logic [4:0] RES  = 5'b01100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_bit, busy, done, crc_ok;
   logic [4:0] crc_val;
`ifdef CRC5_ERRCNT_EN
   logic [7:0] err_count;
`endif

   crc5_serial_unit #(.DATA_BITS(DB), .POLY(POLY), .INIT(INIT), .RESIDUE(RES)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
      .busy(busy), .done(done), .crc_ok(crc_ok), .crc_val(crc_val)
`ifdef CRC5_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Arithmetic form of the per-bit CRC rule.
   function automatic logic [4:0] crc_step(input logic [4:0] r, input logic b);
      int v;
      int f;
      v = int'(r);
      f = ((v >> 4) & 1) ^ (b ? 1 : 0);
      v = ((v * 2) % 32) ^ (f != 0 ? int'(POLY) : 0);
      return 5'(v);
   endfunction

   function automatic logic [4:0] crc_of(input logic [62:0] p);
      logic [4:0] r;
      r = INIT;
      for (int i = 0; i < DB; i++) r = crc_step(r, p[i]);
      return r;
   endfunction

   // Frame model described by counts of accepted/sent bits rather than states.
   bit         model_live = 0;
   bit         m_active = 0, m_done = 0, m_check = 0;
   int         m_nin = 0, m_nout = 0, m_err = 0;
   logic [4:0] m_crc = INIT;
   logic       m_ok = 1'b0;

   function automatic logic exp_in_ready();
      return m_active && (m_nin < DB || (m_check && m_nin < DB + 5));
   endfunction

   function automatic logic exp_out_valid();
      return m_active && !m_check && m_nin == DB && m_nout < 5;
   endfunction

   function automatic logic exp_ok();
      if (m_done) return m_check ? (m_crc == RES) : 1'b1;
      return m_ok;
   endfunction

   always @(posedge clk) begin : model_update
      logic eir, eov;
      eir = exp_in_ready();
      eov = exp_out_valid();
      if (rst) begin
         model_live = 1;
         m_active = 0; m_done = 0; m_check = 0;
         m_nin = 0; m_nout = 0; m_err = 0;
         m_crc = INIT; m_ok = 1'b0;
      end else if (model_live) begin
         if (m_done) begin
            m_ok = exp_ok();
            if (m_check && m_crc != RES && m_err < 255) m_err++;
            m_done = 0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1; m_check = mode;
               m_nin = 0; m_nout = 0;
               m_crc = INIT; m_ok = 1'b0;
            end
         end else if (in_valid && eir) begin
            m_crc = crc_step(m_crc, in_bit);
            m_nin++;
            if (m_nin == DB + 5) begin m_active = 0; m_done = 1; end
         end else if (eov && out_ready) begin
            m_crc = 5'((int'(m_crc) * 2) % 32);
            m_nout++;
            if (m_nout == 5) begin m_active = 0; m_done = 1; end
         end
      end
   end

   int         done_cnt = 0;
   logic [4:0] out_seq = 5'd0;

   always @(negedge clk) begin
      if (model_live) begin
         chk1("busy", busy, m_active || m_done);
         chk1("in_ready", in_ready, exp_in_ready());
         chk1("out_valid", out_valid, exp_out_valid());
         if (exp_out_valid()) chk1("out_bit", out_bit, ~m_crc[4]);
         chk1("done", done, m_done);
         chk5("crc_val", crc_val, m_crc);
         chk1("crc_ok", crc_ok, exp_ok());
`ifdef CRC5_ERRCNT_EN
         chk8("err_count", err_count, 8'(m_err));
`endif
         if (done === 1'b1) done_cnt++;
         if (out_valid === 1'b1 && out_ready) out_seq = {out_seq[3:0], out_bit};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] crc_data, crc_end;
   logic       ok_end;

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      if (done !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout @%0t: got no done expected done within %0d cycles", $time, budget);
      end
      crc_end = crc_val;
      ok_end  = crc_ok;
      tick();
   endtask

   task automatic run_frame(input logic chk_mode, input logic [62:0] payload,
                            input logic [4:0] tail, input bit gap, input int stall, input bit stray);
      out_seq = 5'd0;
      start = 1'b1; mode = chk_mode;
      tick();
      start = 1'b0; mode = 1'b0;
      for (int i = 0; i < DB; i++) begin
         if (gap) begin
            in_valid = 1'b0; in_bit = 1'b1; start = stray;
            tick();
            start = 1'b0;
         end
         in_valid = 1'b1; in_bit = payload[i];
         tick();
      end
      in_valid = 1'b0; in_bit = 1'b0;
      crc_data = crc_val;
      if (chk_mode) begin
         for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_bit = tail[4-j];
            tick();
         end
         in_valid = 1'b0; in_bit = 1'b0;
         wait_done(4);
      end else begin
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) tick();
         out_ready = 1'b1;
         wait_done(12);
         out_ready = 1'b0;
      end
      $display("frame mode=%0d data_crc=%b end_crc=%b crc_ok=%b out_seq=%b", chk_mode, crc_data, crc_end, ok_end, out_seq);
   endtask

   localparam logic [62:0] PAY = 63'b10110011010;
   logic [4:0] pay_crc;
   int         dc;

   initial begin
      #200000;
      $display("FAIL watchdog @%0t: got no finish expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick(); tick(); tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_bit", out_bit, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_crc_ok", crc_ok, 1'b0);
      chk5("rst_crc_val", crc_val, 5'b11111);
      rst = 1'b0;
      tick();

      chk5("model_pin_zero", crc_of(63'd0), 5'b10111);

      // Reset held 2 cycles in the middle of DATA.
      dc = done_cnt;
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin in_valid = 1'b1; in_bit = 1'b1; tick(); end
      in_valid = 1'b0; rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b0);
      chk5("abort_crc_val", crc_val, 5'b11111);
      tick(); tick();
      chk1("abort_no_done", done_cnt == dc, 1'b1);
      $display("frame reset-abort busy=%b crc_val=%b", busy, crc_val);

      run_frame(1'b0, 63'd0, 5'd0, 1'b0, 0, 1'b0);
      chk5("gen_data_crc", crc_data, 5'b10111);
      chk5("gen_out_seq", out_seq, 5'b01000);
      chk1("gen_ok", ok_end, 1'b1);

      run_frame(1'b1, 63'd0, 5'b01000, 1'b0, 0, 1'b0);
      chk5("chk_good_crc", crc_end, 5'b01100);
      chk1("chk_good_ok", ok_end, 1'b1);

      run_frame(1'b1, 63'd0, 5'b00000, 1'b0, 0, 1'b0);
      chk5("chk_bad_crc", crc_end, 5'b00001);
      chk1("chk_bad_ok", ok_end, 1'b0);
      chk1("chk_bad_ok_hold", crc_ok, 1'b0);
`ifdef CRC5_ERRCNT_EN
      chk8("errcnt_one", err_count, 8'd1);
`endif

      run_frame(1'b0, 63'd0, 5'd0, 1'b0, 3, 1'b0);
      chk5("stall_out_seq", out_seq, 5'b01000);
      chk5("stall_end_crc", crc_end, 5'b00000);

      run_frame(1'b0, 63'd0, 5'd0, 1'b1, 0, 1'b1);
      chk5("gap_data_crc", crc_data, 5'b10111);
      chk5("gap_out_seq", out_seq, 5'b01000);

      pay_crc = crc_of(PAY);
      run_frame(1'b0, PAY, 5'd0, 1'b0, 1, 1'b0);
      chk5("pay_data_crc", crc_data, pay_crc);
      chk5("pay_out_seq", out_seq, ~pay_crc);

      run_frame(1'b1, PAY, ~pay_crc, 1'b1, 0, 1'b0);
      chk5("pay_chk_crc", crc_end, RES);
      chk1("pay_chk_ok", ok_end, 1'b1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
